// File: rtl/cocotb_array_serializer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : cocotb_array_serializer
// Brief    : Transmit side of the multi-dimension array round-trip design.
//            Accepts one 27-bit frame (3x3 array of 3-bit entries) on a
//            valid/ready input and streams the nine entries out, one per
//            cycle, on a valid/ready output tagged with outer/inner indices
//            and first/last flags. Counts completed frames.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   LSB_FIRST    1: emit entry [0][0] first (ascending); 0: [2][2] first.
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   in_data      27-bit frame, entry [o][i] at bits (3*o+i)*3 +: 3
//   in_valid     frame offered
//   in_ready     frame accepted on in_valid && in_ready
//   out_data     current 3-bit entry
//   out_outer    outer index (0..2) of current entry
//   out_inner    inner index (0..2) of current entry
//   out_first    current entry is first of its frame
//   out_last     current entry is last of its frame
//   out_valid    entry offered
//   out_ready    entry consumed on out_valid && out_ready
//   frame_count  completed frames, wraps 255 -> 0
// Optional (macro COCOTB_ARRAY_SER_PARITY_EN):
//   out_parity            XOR of out_data while valid, else 0
//   in_parity_err_inject  sampled on input handshake; inverts out_parity
//                         for every entry of that frame
// ============================================================================
module cocotb_array_serializer #(
    parameter int LSB_FIRST = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [26:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [2:0]  out_data,
    output logic [1:0]  out_outer,
    output logic [1:0]  out_inner,
    output logic        out_first,
    output logic        out_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  frame_count
`ifdef COCOTB_ARRAY_SER_PARITY_EN
    ,
    output logic        out_parity,
    input  logic        in_parity_err_inject
`endif
);

    localparam logic [0:0] c_ST_IDLE   = 1'b0;
    localparam logic [0:0] c_ST_SEND   = 1'b1;
    localparam logic [3:0] c_LAST_BEAT = 4'd8;

    logic [0:0]  r_state;
    logic [26:0] r_frame;
    logic [3:0]  r_beat;
    logic [7:0]  r_frame_count;

    logic [0:0]  w_state_nxt;
    logic [26:0] w_frame_nxt;
    logic [3:0]  w_beat_nxt;
    logic [7:0]  w_count_nxt;

    logic        w_send;
    logic        w_is_last;
    logic        w_load;
    logic [3:0]  w_entry_idx;
    logic [4:0]  w_bit_base;
    logic [2:0]  w_entry;
    logic [1:0]  w_outer;
    logic [1:0]  w_inner;

`ifdef COCOTB_ARRAY_SER_PARITY_EN
    logic        r_par_inv;
    logic        w_par_inv_nxt;
`endif

    assign w_send    = (r_state == c_ST_SEND);
    assign w_is_last = w_send && (r_beat == c_LAST_BEAT);

    // Ready is combinational from out_ready on the last beat so the next
    // frame can be loaded on the same edge the last entry is consumed.
    assign in_ready = (r_state == c_ST_IDLE) || (w_is_last && out_ready);
    assign w_load   = in_valid && in_ready;

    // Beat counter always runs 0..8; emission order only changes which
    // entry that beat selects.
    generate
        if (LSB_FIRST != 0) begin : g_lsb_first
            assign w_entry_idx = r_beat;
        end else begin : g_msb_first
            assign w_entry_idx = c_LAST_BEAT - r_beat;
        end
    endgenerate

    // Flat entry index to (outer, inner) without a divider.
    always_comb begin
        w_outer = 2'd0;
        w_inner = 2'd0;
        case (w_entry_idx)
            4'd0: begin w_outer = 2'd0; w_inner = 2'd0; end
            4'd1: begin w_outer = 2'd0; w_inner = 2'd1; end
            4'd2: begin w_outer = 2'd0; w_inner = 2'd2; end
            4'd3: begin w_outer = 2'd1; w_inner = 2'd0; end
            4'd4: begin w_outer = 2'd1; w_inner = 2'd1; end
            4'd5: begin w_outer = 2'd1; w_inner = 2'd2; end
            4'd6: begin w_outer = 2'd2; w_inner = 2'd0; end
            4'd7: begin w_outer = 2'd2; w_inner = 2'd1; end
            4'd8: begin w_outer = 2'd2; w_inner = 2'd2; end
            default: begin w_outer = 2'd0; w_inner = 2'd0; end
        endcase
    end

    assign w_bit_base = {1'b0, w_entry_idx} * 5'd3;
    assign w_entry    = r_frame[w_bit_base +: 3];

    // Next-state logic; a load overrides whatever the case decided.
    always_comb begin
        w_state_nxt = r_state;
        w_frame_nxt = r_frame;
        w_beat_nxt  = r_beat;
        w_count_nxt = r_frame_count;
`ifdef COCOTB_ARRAY_SER_PARITY_EN
        w_par_inv_nxt = r_par_inv;
`endif
        case (r_state)
            c_ST_IDLE: begin
                w_state_nxt = c_ST_IDLE;
            end
            c_ST_SEND: begin
                if (out_ready) begin
                    if (r_beat != c_LAST_BEAT) begin
                        w_beat_nxt = r_beat + 4'd1;
                    end else begin
                        w_count_nxt = r_frame_count + 8'd1;
                        w_state_nxt = c_ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
        if (w_load) begin
            w_state_nxt = c_ST_SEND;
            w_frame_nxt = in_data;
            w_beat_nxt  = 4'd0;
`ifdef COCOTB_ARRAY_SER_PARITY_EN
            w_par_inv_nxt = in_parity_err_inject;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_ST_IDLE;
            r_frame       <= '0;
            r_beat        <= 4'd0;
            r_frame_count <= 8'd0;
`ifdef COCOTB_ARRAY_SER_PARITY_EN
            r_par_inv     <= 1'b0;
`endif
        end else begin
            r_state       <= w_state_nxt;
            r_frame       <= w_frame_nxt;
            r_beat        <= w_beat_nxt;
            r_frame_count <= w_count_nxt;
`ifdef COCOTB_ARRAY_SER_PARITY_EN
            r_par_inv     <= w_par_inv_nxt;
`endif
        end
    end

    // All entry-related outputs read as zero outside SEND.
    assign out_valid   = w_send;
    assign out_data    = w_send ? w_entry : 3'd0;
    assign out_outer   = w_send ? w_outer : 2'd0;
    assign out_inner   = w_send ? w_inner : 2'd0;
    assign out_first   = w_send && (r_beat == 4'd0);
    assign out_last    = w_is_last;
    assign frame_count = r_frame_count;

`ifdef COCOTB_ARRAY_SER_PARITY_EN
    assign out_parity  = w_send ? ((^w_entry) ^ r_par_inv) : 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cocotb_array_serializer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_cocotb_array_serializer
// Brief    : Scoreboard bench for cocotb_array_serializer. Two instances
//            (ascending and descending order) share one stimulus stream;
//            expected entries are queued when a frame is offered and a
//            monitor compares them whenever an instance presents an entry.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cocotb_array_serializer;

    typedef struct packed {
        logic [2:0] data;
        logic [1:0] outer;
        logic [1:0] inner;
        logic       first;
        logic       last;
        logic       par;
    } beat_t;

    typedef logic [2:0] ent_arr_t [9];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [26:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        or_force = 1'b1;
    logic        rand_mode = 1'b0;
    logic        inj = 1'b0;

    logic        ir_a, ir_b, ov_a, ov_b, of_a, of_b, ol_a, ol_b;
    logic [2:0]  od_a, od_b;
    logic [1:0]  oo_a, oo_b, oi_a, oi_b;
    logic [7:0]  fc_a, fc_b;
    logic        par_a, par_b;
    beat_t       got_a, got_b;

    beat_t       qa[$];
    beat_t       qb[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          run_len = 0;
    int          max_run = 0;
    int          bad_ir = 0;
    logic [7:0]  exp_fc = 8'd0;

    cocotb_array_serializer #(.LSB_FIRST(1)) u_dut_lsb (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(ir_a), .out_data(od_a), .out_outer(oo_a), .out_inner(oi_a),
        .out_first(of_a), .out_last(ol_a), .out_valid(ov_a),
        .out_ready(out_ready), .frame_count(fc_a)
`ifdef COCOTB_ARRAY_SER_PARITY_EN
        , .out_parity(par_a), .in_parity_err_inject(inj)
`endif
    );

    cocotb_array_serializer #(.LSB_FIRST(0)) u_dut_msb (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(ir_b), .out_data(od_b), .out_outer(oo_b), .out_inner(oi_b),
        .out_first(of_b), .out_last(ol_b), .out_valid(ov_b),
        .out_ready(out_ready), .frame_count(fc_b)
`ifdef COCOTB_ARRAY_SER_PARITY_EN
        , .out_parity(par_b), .in_parity_err_inject(inj)
`endif
    );

`ifndef COCOTB_ARRAY_SER_PARITY_EN
    assign par_a = 1'b0;
    assign par_b = 1'b0;
`endif

    assign got_a = {od_a, oo_a, oi_a, of_a, ol_a, par_a};
    assign got_b = {od_b, oo_b, oi_b, of_b, ol_b, par_b};

    always #5 clk = ~clk;

    // out_ready changes 2 ns after the edge; stimulus moves at +1 ns.
    always @(posedge clk) begin
        #2;
        out_ready = rand_mode ? ($urandom_range(1) != 0) : or_force;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Expected entry b of a frame for a given emission order.
    function automatic beat_t mk(input ent_arr_t e, input int b, input bit lsb, input logic pinv);
        beat_t r;
        int    idx;
        idx     = lsb ? b : 8 - b;
        r.data  = e[idx];
        r.outer = 2'(idx / 3);
        r.inner = 2'(idx % 3);
        r.first = (b == 0);
        r.last  = (b == 8);
`ifdef COCOTB_ARRAY_SER_PARITY_EN
        r.par   = (^e[idx]) ^ pinv;
`else
        r.par   = 1'b0 & pinv;
`endif
        return r;
    endfunction

    // Monitor: every valid cycle must show the queue head (this also proves
    // outputs hold while stalled); the head is popped on the handshake.
    always @(negedge clk) begin
        if (rst) begin
            run_len = 0;
        end else begin
            if (ov_a) begin
                run_len++;
                if (run_len > max_run) max_run = run_len;
            end else begin
                run_len = 0;
            end
            if ((ov_a && ir_a && !ol_a) || (ov_b && ir_b && !ol_b)) bad_ir++;
            if (ov_a) begin
                if (qa.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL lsb_unexpected_beat: got %0h expected none", got_a);
                end else begin
                    check("lsb_beat", 32'(got_a), 32'(qa[0]));
                    if (out_ready) void'(qa.pop_front());
                end
            end
            if (ov_b) begin
                if (qb.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL msb_unexpected_beat: got %0h expected none", got_b);
                end else begin
                    check("msb_beat", 32'(got_b), 32'(qb[0]));
                    if (out_ready) void'(qb.pop_front());
                end
            end
        end
    end

    task automatic send_frame(input ent_arr_t e, input logic pinv);
        logic [26:0] f;
        bit          ok;
        f = '0;
        for (int b = 0; b < 9; b++) f[b*3 +: 3] = e[b];
        for (int b = 0; b < 9; b++) begin
            qa.push_back(mk(e, b, 1'b1, pinv));
            qb.push_back(mk(e, b, 1'b0, pinv));
        end
        in_data  = f;
        in_valid = 1'b1;
        inj      = pinv;
        ok       = 1'b0;
        for (int c = 0; c < 2000 && !ok; c++) begin
            @(negedge clk);
            if (ir_a) ok = 1'b1;
        end
        if (!ok) begin
            n_cmp++; n_fail++;
            $display("FAIL in_handshake_timeout: got in_ready 0 expected 1");
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            exp_fc   = exp_fc + 8'd1;
        end
    endtask

    task automatic wait_drain();
        int c;
        c = 0;
        while ((qa.size() != 0 || qb.size() != 0) && c < 5000) begin
            @(negedge clk);
            c++;
        end
        if (qa.size() != 0 || qb.size() != 0) begin
            n_cmp++; n_fail++;
            $display("FAIL drain_timeout: got %0d pending expected 0", qa.size() + qb.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ent_arr_t t_seq;
        ent_arr_t t_alt;
        ent_arr_t t_rnd;
        t_seq = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
        t_alt = '{3'd5, 3'd2, 3'd7, 3'd1, 3'd6, 3'd3, 3'd0, 3'd4, 3'd6};

        // Reset state, checked while reset is held.
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  32'(ir_a), 32'd1);
        check("rst_out_valid", 32'(ov_a), 32'd0);
        check("rst_outputs",   32'(got_a), 32'd0);
        check("rst_msb_valid", 32'(ov_b), 32'd0);
        check("rst_fcount",    32'(fc_a), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single frame, both emission orders.
        send_frame(t_seq, 1'b0);
        wait_drain();
        check("fc_single_lsb", 32'(fc_a), 32'(exp_fc));
        check("fc_single_msb", 32'(fc_b), 32'(exp_fc));

        // Back-to-back frames: 18 valid cycles in a row, ready only on last.
        max_run = 0;
        bad_ir  = 0;
        send_frame(t_alt, 1'b0);
        send_frame(t_seq, 1'b0);
        wait_drain();
        check("b2b_run_len",   32'(max_run), 32'd18);
        check("b2b_ready_mid", 32'(bad_ir), 32'd0);
        check("fc_b2b",        32'(fc_a), 32'(exp_fc));

        // Random backpressure over 20 frames.
        rand_mode = 1'b1;
        for (int k = 0; k < 20; k++) begin
            for (int b = 0; b < 9; b++) t_rnd[b] = 3'($urandom_range(7));
            send_frame(t_rnd, 1'b0);
        end
        wait_drain();
        rand_mode = 1'b0;
        check("fc_random_lsb", 32'(fc_a), 32'(exp_fc));
        check("fc_random_msb", 32'(fc_b), 32'(exp_fc));
        repeat (2) @(posedge clk);
        #1;

        // Reset in the middle of a frame at beat 4.
        send_frame(t_seq, 1'b0);
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        qa.delete();
        qb.delete();
        exp_fc = 8'd0;
        #1;
        check("midrst_valid",    32'(ov_a), 32'd0);
        check("midrst_msb_vld",  32'(ov_b), 32'd0);
        check("midrst_in_ready", 32'(ir_a), 32'd1);
        check("midrst_outputs",  32'(got_a), 32'd0);
        check("midrst_fcount",   32'(fc_a), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        send_frame(t_alt, 1'b0);
        wait_drain();
        check("fc_after_rst", 32'(fc_a), 32'(exp_fc));

        // frame_count wrap: 255 more frames takes it from 1 to 0.
        for (int k = 0; k < 255; k++) begin
            for (int b = 0; b < 9; b++) t_rnd[b] = 3'(k + b);
            send_frame(t_rnd, 1'b0);
        end
        wait_drain();
        check("fc_wrap_lsb", 32'(fc_a), 32'd0);
        check("fc_wrap_msb", 32'(fc_b), 32'd0);

`ifdef COCOTB_ARRAY_SER_PARITY_EN
        // 3'b011 -> parity 0, 3'b111 -> parity 1; inverted with inject.
        t_rnd = '{3'b011, 3'b111, 3'b011, 3'b111, 3'b011, 3'b111, 3'b011, 3'b111, 3'b011};
        send_frame(t_rnd, 1'b0);
        send_frame(t_rnd, 1'b1);
        wait_drain();
        check("fc_parity", 32'(fc_a), 32'(exp_fc));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
